// File: rtl/bar_sample_history.sv
// Sample averager, iterative scaler and frame-gated 32-entry height history
// feeding the VGA bar-graph renderer; column 0 of the read port is the newest bar.
module bar_sample_history #(
  parameter int DEPTH    = 32,
  parameter int AVG_LOG2 = 2,
  parameter int DW       = 12,
  parameter int HW       = 10,
  parameter int DIVISOR  = 25,
  parameter int OFFSET   = 120,
  parameter int MAX_H    = 479
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic [DW-1:0]            iD,
  input  logic                     iD_valid,
  input  logic                     iFrame_sync,
  input  logic [$clog2(DEPTH)-1:0] iRd_col,
  output logic [HW-1:0]            oRd_h,
  output logic                     oNew,
  output logic                     oDrop,
  output logic                     oBusy
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = DW + AVG_LOG2;
  localparam int CW = $clog2(DW);
  // Scaling width is wide enough for any quotient plus offset, so the clamp sees the true sum.
  localparam int XW = ((DW > HW) ? DW : HW) + 1;

  typedef enum logic [1:0] {IDLE, DIV, SCALE} state_t;

  state_t          state_reg, state_next;
  logic [SW-1:0]   sum_reg;
  logic [AVG_LOG2-1:0] cnt_reg;
  logic [DW-1:0]   rem_reg;
  logic [DW-1:0]   dq_reg;
  logic [CW-1:0]   bit_cnt_reg;
  logic [HW-1:0]   pending_h_reg;
  logic            pending_valid_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [HW-1:0]   rd_h_reg;
  logic            new_reg;
  logic            drop_reg;
  logic [HW-1:0]   mem [DEPTH];

  logic [SW-1:0]   sum_in;
  logic [DW-1:0]   avg;
  logic            batch_done;
  logic [DW-1:0]   trial_lo;
  logic            quot_bit;
  logic [DW-1:0]   rem_step;
  logic [XW-1:0]   scaled;
  logic [HW-1:0]   h_sat;
  logic            commit;
  logic            drop;
  logic [AW-1:0]   rd_idx;

  assign sum_in     = sum_reg + SW'(iD);
  assign avg        = sum_in[SW-1:AVG_LOG2];
  assign batch_done = iD_valid && (cnt_reg == '1);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      sum_reg <= '0;
      cnt_reg <= '0;
    end else if (iD_valid) begin
      sum_reg <= batch_done ? '0 : sum_in;
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Remainder stays below DIVISOR, so a set MSB already guarantees the shifted trial exceeds it.
  assign trial_lo = {rem_reg[DW-2:0], dq_reg[DW-1]};
  assign quot_bit = rem_reg[DW-1] || (trial_lo >= DW'(DIVISOR));
  assign rem_step = quot_bit ? (trial_lo - DW'(DIVISOR)) : trial_lo;

  assign scaled = XW'(dq_reg) + XW'(OFFSET);
  assign h_sat  = (scaled > XW'(MAX_H)) ? HW'(MAX_H) : scaled[HW-1:0];

  assign commit = iFrame_sync && pending_valid_reg;
  assign rd_idx = wr_ptr_reg - AW'(1) - iRd_col;

  always_comb begin
    state_next = state_reg;
    drop       = 1'b0;
    case (state_reg)
      IDLE:  if (batch_done) state_next = DIV;
      DIV: begin
        if (bit_cnt_reg == CW'(DW - 1)) state_next = SCALE;
        drop = batch_done;
      end
      SCALE: begin
        state_next = IDLE;
        drop = batch_done || (pending_valid_reg && !commit);
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_reg         <= IDLE;
      rem_reg           <= '0;
      dq_reg            <= '0;
      bit_cnt_reg       <= '0;
      pending_h_reg     <= '0;
      pending_valid_reg <= 1'b0;
      wr_ptr_reg        <= '0;
      rd_h_reg          <= '0;
      new_reg           <= 1'b0;
      drop_reg          <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && batch_done) begin
        rem_reg     <= '0;
        dq_reg      <= avg;
        bit_cnt_reg <= '0;
      end else if (state_reg == DIV) begin
        rem_reg     <= rem_step;
        dq_reg      <= {dq_reg[DW-2:0], quot_bit};
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
      // A commit on the same edge as a new result takes the old value and stages the new one.
      if (state_reg == SCALE) begin
        pending_h_reg     <= h_sat;
        pending_valid_reg <= 1'b1;
      end else if (commit) begin
        pending_valid_reg <= 1'b0;
      end
      if (commit) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      rd_h_reg <= mem[rd_idx];
      new_reg  <= commit;
      drop_reg <= drop;
    end
  end

  // History entries carry their own reset so unwritten columns read as empty bars.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hist
      always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
          mem[gi] <= '0;
        end else if (commit && (wr_ptr_reg == AW'(gi))) begin
          mem[gi] <= pending_h_reg;
        end
      end
    end
  endgenerate

  assign oRd_h = rd_h_reg;
  assign oNew  = new_reg;
  assign oDrop = drop_reg;
  assign oBusy = (state_reg == DIV);

endmodule

// File: tb/tb_bar_sample_history.sv
// Directed bench for bar_sample_history: a default-scaled instance and a
// unity-divisor/zero-offset instance share the same stimulus.
module tb_bar_sample_history;

  logic        iCLK;
  logic        iRST;
  logic [11:0] iD;
  logic        iD_valid;
  logic        iFrame_sync;
  logic [4:0]  iRd_col;
  logic [9:0]  rd_h, rd_h1;
  logic        new0, new1, drop0, drop1, busy0, busy1;

  int n_checks = 0;
  int n_pass   = 0;

  bar_sample_history dut (
    .iCLK(iCLK), .iRST(iRST), .iD(iD), .iD_valid(iD_valid),
    .iFrame_sync(iFrame_sync), .iRd_col(iRd_col),
    .oRd_h(rd_h), .oNew(new0), .oDrop(drop0), .oBusy(busy0)
  );

  bar_sample_history #(.DIVISOR(1), .OFFSET(0)) dut1 (
    .iCLK(iCLK), .iRST(iRST), .iD(iD), .iD_valid(iD_valid),
    .iFrame_sync(iFrame_sync), .iRd_col(iRd_col),
    .oRd_h(rd_h1), .oNew(new1), .oDrop(drop1), .oBusy(busy1)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic apply_reset();
    iRST = 1'b1;
    step();
    step();
    iRST = 1'b0;
    step();
  endtask

  task automatic send_sample(input logic [11:0] d);
    iD       = d;
    iD_valid = 1'b1;
    step();
    iD_valid = 1'b0;
  endtask

  task automatic send_batch(input logic [11:0] d);
    for (int i = 0; i < 4; i++) send_sample(d);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy0 && k < 40) begin
      step();
      k++;
    end
    if (busy0) begin
      n_checks++;
      $display("FAIL wait_idle: got busy after %0d cycles want idle", k);
    end
  endtask

  // Edge 1 is the SCALE edge, edge 2 commits, edge 3 refreshes the read port.
  task automatic commit_pending();
    step();
    iFrame_sync = 1'b1;
    step();
    iFrame_sync = 1'b0;
    n_checks++;
    if (new0 !== 1'b1) $display("FAIL commit_new: got %0b want 1", new0);
    else n_pass++;
    step();
  endtask

  task automatic read_col(input logic [4:0] c);
    iRd_col = c;
    step();
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    step();
    n_checks++;
    if ({rd_h, new0, drop0, busy0} !== 13'd0)
      $display("FAIL reset_outputs: got h=%0d new=%0b drop=%0b busy=%0b want 0", rd_h, new0, drop0, busy0);
    else n_pass++;
    iRST = 1'b0;
    step();
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int busy_cycles;
    send_batch(12'd1000);
    busy_cycles = 0;
    while (busy0 && busy_cycles < 40) begin
      busy_cycles++;
      step();
    end
    n_checks++;
    if (busy_cycles != 12) $display("FAIL basic_busy_len: got %0d want 12", busy_cycles);
    else n_pass++;
    // The next edge sets pending_valid; a sync on that edge must not commit.
    iFrame_sync = 1'b1;
    step();
    iFrame_sync = 1'b0;
    n_checks++;
    if (new0 !== 1'b0) $display("FAIL basic_coincident_sync: got new=%0b want 0", new0);
    else n_pass++;
    step();
    n_checks++;
    if (rd_h !== 10'd0) $display("FAIL basic_gated_col0: got %0d want 0", rd_h);
    else n_pass++;
    iFrame_sync = 1'b1;
    step();
    iFrame_sync = 1'b0;
    n_checks++;
    if (new0 !== 1'b1) $display("FAIL basic_new: got %0b want 1", new0);
    else n_pass++;
    step();
    n_checks++;
    if (rd_h !== 10'd160) $display("FAIL basic_col0: got %0d want 160", rd_h);
    else n_pass++;
    n_checks++;
    if (new0 !== 1'b0) $display("FAIL basic_new_width: got %0b want 0", new0);
    else n_pass++;
    $display("test_basic: 4x1000 -> col0=%0d", rd_h);
  endtask

  task automatic test_trunc_sat();
    send_sample(12'd4095);
    send_sample(12'd4095);
    send_sample(12'd4095);
    send_sample(12'd4094);
    wait_idle();
    commit_pending();
    n_checks++;
    if (rd_h !== 10'd283) $display("FAIL trunc_col0: got %0d want 283", rd_h);
    else n_pass++;
    n_checks++;
    if (rd_h1 !== 10'd479) $display("FAIL trunc_sat_col0: got %0d want 479", rd_h1);
    else n_pass++;
    read_col(5'd1);
    n_checks++;
    if (rd_h !== 10'd160) $display("FAIL trunc_col1: got %0d want 160", rd_h);
    else n_pass++;
    iRd_col = 5'd0;
    send_batch(12'd4095);
    wait_idle();
    commit_pending();
    n_checks++;
    if (rd_h1 !== 10'd479) $display("FAIL sat_max_col0: got %0d want 479", rd_h1);
    else n_pass++;
    $display("test_trunc_sat: col0=%0d sat=%0d", rd_h, rd_h1);
  endtask

  task automatic test_drop();
    apply_reset();
    iRd_col = 5'd0;
    send_batch(12'd1000);
    send_batch(12'd500);
    n_checks++;
    if (drop0 !== 1'b1) $display("FAIL drop_busy_pulse: got %0b want 1", drop0);
    else n_pass++;
    step();
    n_checks++;
    if (drop0 !== 1'b0) $display("FAIL drop_busy_width: got %0b want 0", drop0);
    else n_pass++;
    wait_idle();
    commit_pending();
    n_checks++;
    if (rd_h !== 10'd160) $display("FAIL drop_busy_col0: got %0d want 160", rd_h);
    else n_pass++;
    read_col(5'd1);
    n_checks++;
    if (rd_h !== 10'd0) $display("FAIL drop_busy_col1: got %0d want 0", rd_h);
    else n_pass++;
    iRd_col = 5'd0;
    send_batch(12'd250);
    wait_idle();
    step();
    send_batch(12'd750);
    wait_idle();
    step();
    n_checks++;
    if (drop0 !== 1'b1) $display("FAIL drop_overwrite_pulse: got %0b want 1", drop0);
    else n_pass++;
    commit_pending();
    n_checks++;
    if (rd_h !== 10'd150) $display("FAIL drop_overwrite_col0: got %0d want 150", rd_h);
    else n_pass++;
    read_col(5'd1);
    n_checks++;
    if (rd_h !== 10'd160) $display("FAIL drop_overwrite_col1: got %0d want 160", rd_h);
    else n_pass++;
    iRd_col = 5'd0;
    $display("test_drop: col0=%0d col1=%0d", 150, rd_h);
  endtask

  task automatic test_wrap();
    apply_reset();
    iRd_col = 5'd0;
    for (int x = 1; x <= 33; x++) begin
      send_batch(12'(x));
      wait_idle();
      commit_pending();
      if (x == 5) begin
        read_col(5'd4);
        n_checks++;
        if (rd_h1 !== 10'd1) $display("FAIL wrap_pre_col4: got %0d want 1", rd_h1);
        else n_pass++;
        read_col(5'd5);
        n_checks++;
        if (rd_h1 !== 10'd0) $display("FAIL wrap_unwritten_col5: got %0d want 0", rd_h1);
        else n_pass++;
        iRd_col = 5'd0;
      end
    end
    step();
    n_checks++;
    if (rd_h1 !== 10'd33) $display("FAIL wrap_col0: got %0d want 33", rd_h1);
    else n_pass++;
    read_col(5'd31);
    n_checks++;
    if (rd_h1 !== 10'd2) $display("FAIL wrap_col31: got %0d want 2", rd_h1);
    else n_pass++;
    read_col(5'd30);
    n_checks++;
    if (rd_h1 !== 10'd3) $display("FAIL wrap_col30: got %0d want 3", rd_h1);
    else n_pass++;
    iRd_col = 5'd0;
    $display("test_wrap: 33 commits, col31=%0d", rd_h1);
  endtask

  task automatic test_reset_mid();
    iRd_col = 5'd0;
    send_batch(12'd1000);
    send_sample(12'd3000);
    send_sample(12'd3000);
    n_checks++;
    if (busy0 !== 1'b1) $display("FAIL resetmid_busy_before: got %0b want 1", busy0);
    else n_pass++;
    #2;
    iRST = 1'b1;
    #1;
    n_checks++;
    if ({rd_h, new0, drop0, busy0} !== 13'd0)
      $display("FAIL resetmid_outputs: got h=%0d new=%0b drop=%0b busy=%0b want 0", rd_h, new0, drop0, busy0);
    else n_pass++;
    step();
    step();
    iRST = 1'b0;
    read_col(5'd0);
    n_checks++;
    if (rd_h1 !== 10'd0) $display("FAIL resetmid_col0: got %0d want 0", rd_h1);
    else n_pass++;
    read_col(5'd31);
    n_checks++;
    if (rd_h1 !== 10'd0) $display("FAIL resetmid_col31: got %0d want 0", rd_h1);
    else n_pass++;
    iRd_col = 5'd0;
    send_sample(12'd2000);
    send_sample(12'd2000);
    n_checks++;
    if (busy0 !== 1'b0) $display("FAIL resetmid_fresh_batch: got busy=%0b want 0", busy0);
    else n_pass++;
    send_sample(12'd2000);
    send_sample(12'd2000);
    wait_idle();
    commit_pending();
    n_checks++;
    if (rd_h !== 10'd200) $display("FAIL resetmid_first_h: got %0d want 200", rd_h);
    else n_pass++;
    $display("test_reset_mid: first height after reset=%0d", rd_h);
  endtask

  initial begin
    iRST        = 1'b1;
    iD          = '0;
    iD_valid    = 1'b0;
    iFrame_sync = 1'b0;
    iRd_col     = '0;
    test_reset();
    test_basic();
    test_trunc_sat();
    test_drop();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
